fsm_core_arbiter: RTL and testbench
===================================

# fsm_core_arbiter

Controller that shares one two-input/two-output state-machine core between two requesters. It grants the core per packet in round-robin order and restores and saves each requester's 2-bit state context around its packet. It steps the core one symbol per handshake and returns the core outputs as a buffered response stream. It sits between the stimulus sources and the core; the core only sees `step`/`load` strobes from this block.

## Interface
- `CTX_RESET`, default 2'b00: context value loaded into every requester slot at reset.
- `MAX_LEN`, default 15: maximum symbols per grant; range 1..15, held in a 4-bit counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req0_valid`, `req1_valid` in 1: requester has a symbol.
- `req0_sym`, `req1_sym` in 2: symbol {X1,X2}.
- `req0_last`, `req1_last` in 1: symbol ends the packet.
- `req0_ready`, `req1_ready` out 1: symbol accepted when valid&ready.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_z` out 2: {Z1,Z2} sampled from core.
- `rsp_id` out 1: requester that produced the response.
- `rsp_last` out 1: final response of this grant.
- `core_x` out 2: symbol to core; 0 when not stepping.
- `core_step` out 1: core advances state at this edge.
- `core_load` out 1: core loads `core_ctx` at this edge.
- `core_ctx` out 2: context to load.
- `core_state` in 2: core's current state bits {S1,S2}.
- `core_z` in 2: core Mealy outputs for the current state and `core_x`, combinational.
- `busy` out 1: state is not IDLE.
- `grant_id` out 1: current or last granted requester.

## Operation
- States: IDLE, LOAD, RUN, SAVE.
- IDLE, no valid requester: stay in IDLE.
- IDLE, one or both valid: pick a requester round-robin. The requester not granted last wins a tie; after reset req0 wins. Register `grant_id`, clear the length counter, go to LOAD.
- LOAD: `core_load`=1 and `core_ctx`=ctx[`grant_id`] for one cycle, then RUN.
- RUN: `reqG_ready` = (!`rsp_valid` | `rsp_ready`). The other requester's ready is 0.
  - On handshake: `core_x`=sym and `core_step`=1. The response register captures `core_z`, `grant_id`, and last flag = sym_last | (count==MAX_LEN-1). The counter increments.
  - If the last flag is set, go to SAVE; otherwise stay in RUN.
  - If `valid` drops, RUN waits indefinitely with no step.
- SAVE: ctx[`grant_id`] <= `core_state`, which holds the post-step state. Update the round-robin pointer. Go to IDLE.
- Forced cut at MAX_LEN: `rsp_last`=1 even though `req_last`=0. Remaining symbols resume in a later grant from the saved context.
- Response register: 1 entry; it clears on `rsp_ready` unless refilled the same cycle.
- `core_step` and `core_load` are never high together.

## Timing
- Reset: all outputs 0; FSM in IDLE; both contexts = CTX_RESET; round-robin pointer favours req0.
- `rst_n` low mid-packet aborts immediately, with no SAVE. Pending responses are lost.
- Grant latency: valid seen in IDLE at cycle n → LOAD at n+1 → ready high at n+2 if the response slot is free.
- Response latency: `rsp_valid` is high the cycle after the accepting edge. Throughput is 1 symbol/cycle while `rsp_ready`=1.
- Turnaround: SAVE is 1 cycle and IDLE is at least 1 cycle, so at least 3 dead cycles between packets.
- `rsp_valid`, `rsp_z`, `rsp_id`, and `rsp_last` are held stable while `rsp_valid`&!`rsp_ready`.

## Configuration
- `ARB_CTX_SAVE_EN` defined: behaviour as above. Per-requester contexts persist across grants.
- `ARB_CTX_SAVE_EN` undefined:
  - No context storage.
  - LOAD always drives `core_ctx`=CTX_RESET.
  - SAVE still occupies one cycle but writes nothing.
  - `core_state` is unused.

## Test plan
Bench core model: state += 1 mod 4 on step, load sets state, `core_z`=state.
- Reset with `rst_n`=0 while req0 is valid → all outputs 0; after release, `core_ctx`=00 in LOAD and req0 is granted.
- Both valid at once, 2-symbol packets each, `rsp_ready`=1 → grants alternate 0,1,0.
  - req0 responses are `rsp_z`=0,1 then 2,3 (context restored 2).
  - req1 responses are 0,1.
- `MAX_LEN`=3 with a 5-symbol req0 packet → `rsp_last` on the 3rd response; SAVE stores 3; the next grant LOAD drives `core_ctx`=3.
- `rsp_ready`=0 for 4 cycles mid-packet → exactly one `core_step`; `rsp_z`/`rsp_id` held; no step until `rsp_ready` rises.
- `rst_n` pulsed during RUN after 2 steps → outputs 0 immediately; ctx[0] returns to CTX_RESET.
- `ARB_CTX_SAVE_EN` undefined, repeat the alternating test → every LOAD drives `core_ctx`=00 and each packet starts at `rsp_z`=0.

Source files
------------

// File: rtl/fsm_core_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fsm_core_arbiter_if
// Brief    : Request / response handshake bundle for fsm_core_arbiter.
//            master = stimulus source and response consumer.
//            slave  = the arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface fsm_core_arbiter_if;
    logic       req0_valid;
    logic [1:0] req0_sym;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [1:0] req1_sym;
    logic       req1_last;
    logic       req1_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_z;
    logic       rsp_id;
    logic       rsp_last;

    modport master (
        output req0_valid, req0_sym, req0_last,
        output req1_valid, req1_sym, req1_last,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_z, rsp_id, rsp_last,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_sym, req0_last,
        input  req1_valid, req1_sym, req1_last,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_z, rsp_id, rsp_last,
        input  rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/fsm_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fsm_core_arbiter
// Brief    : Shares one 2-in/2-out state-machine core between two
//            requesters. Round-robin grant per packet, restores / saves each
//            requester's 2-bit core context around its packet, steps the core
//            one symbol per handshake and returns the core outputs through a
//            one-entry response register.
//            Optional feature macro: ARB_CTX_SAVE_EN (per-requester context
//            storage). Without it every packet starts from CTX_RESET.
// Revision : 1.0  initial release
// ============================================================================
module fsm_core_arbiter #(
    parameter logic [1:0]  CTX_RESET = 2'b00,
    parameter int unsigned MAX_LEN   = 15
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fsm_core_arbiter_if.slave bus,
    output logic [1:0]      core_x,
    output logic            core_step,
    output logic            core_load,
    output logic [1:0]      core_ctx,
    input  wire logic [1:0] core_state,
    input  wire logic [1:0] core_z,
    output logic            busy,
    output logic            grant_id
);

    // Count value at which the current symbol is the last one of a grant.
    localparam logic [3:0] C_LAST_CNT = 4'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_SAVE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_q, rr_d;          // requester preferred on a tie
    logic [3:0] cnt_q, cnt_d;        // symbols accepted in this grant
    logic       rsp_valid_q, rsp_valid_d;
    logic [1:0] rsp_z_q, rsp_z_d;
    logic       rsp_id_q, rsp_id_d;
    logic       rsp_last_q, rsp_last_d;

    logic       w_slot_free;
    logic       w_run;
    logic       w_g_valid;
    logic [1:0] w_g_sym;
    logic       w_g_last;
    logic       w_hs;
    logic       w_last;
    logic [1:0] w_load_ctx;

`ifdef ARB_CTX_SAVE_EN
    logic [1:0] ctx_q [2];
    logic [1:0] ctx_d [2];
    assign w_load_ctx = ctx_q[grant_q];
`else
    // The core state is only needed when contexts are saved.
    logic w_unused_core_state;
    assign w_unused_core_state = ^core_state;
    assign w_load_ctx          = CTX_RESET;
`endif

    // Handshake decode for the granted requester and core strobes.
    always_comb begin
        w_slot_free = !rsp_valid_q || bus.rsp_ready;
        w_run       = (state_q == ST_RUN);
        w_g_valid   = grant_q ? bus.req1_valid : bus.req0_valid;
        w_g_sym     = grant_q ? bus.req1_sym   : bus.req0_sym;
        w_g_last    = grant_q ? bus.req1_last  : bus.req0_last;
        w_hs        = w_run && w_slot_free && w_g_valid;
        // A grant ends on the packet's own last symbol or on the length cap.
        w_last      = w_g_last || (cnt_q == C_LAST_CNT);
    end

    assign bus.req0_ready = w_run && w_slot_free && !grant_q;
    assign bus.req1_ready = w_run && w_slot_free &&  grant_q;
    assign core_step      = w_hs;
    assign core_x         = w_hs ? w_g_sym : 2'b00;
    assign core_load      = (state_q == ST_LOAD);
    assign core_ctx       = core_load ? w_load_ctx : 2'b00;
    assign busy           = (state_q != ST_IDLE);
    assign grant_id       = grant_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_last   = rsp_last_q;

    // Next-state logic for the grant FSM, length counter and response slot.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_z_d     = rsp_z_q;
        rsp_id_d    = rsp_id_q;
        rsp_last_d  = rsp_last_q;
`ifdef ARB_CTX_SAVE_EN
        ctx_d       = ctx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    // On a tie the requester not served last wins.
                    grant_d = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
                    cnt_d   = 4'd0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 4'd1;
                    if (w_last) begin
                        state_d = ST_SAVE;
                    end
                end
            end
            ST_SAVE: begin
`ifdef ARB_CTX_SAVE_EN
                // The core has already applied the final step here.
                ctx_d[grant_q] = core_state;
`endif
                rr_d    = ~grant_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Refill wins over drain so a back-to-back stream never bubbles.
        if (w_hs) begin
            rsp_valid_d = 1'b1;
            rsp_z_d     = core_z;
            rsp_id_d    = grant_q;
            rsp_last_d  = w_last;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; reset aborts any packet without saving its context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            rr_q        <= 1'b0;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= 2'b00;
            rsp_id_q    <= 1'b0;
            rsp_last_q  <= 1'b0;
`ifdef ARB_CTX_SAVE_EN
            ctx_q[0]    <= CTX_RESET;
            ctx_q[1]    <= CTX_RESET;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            rsp_id_q    <= rsp_id_d;
            rsp_last_q  <= rsp_last_d;
`ifdef ARB_CTX_SAVE_EN
            ctx_q       <= ctx_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fsm_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_core_arbiter
// Brief    : Self-checking bench for fsm_core_arbiter (MAX_LEN = 3) with a
//            behavioural core: load sets state, step adds 1 mod 4, z = state.
//            Expected responses and LOAD contexts are queued when stimulus
//            starts and compared as the DUT produces them.
// Revision : 1.0  initial release
// ============================================================================
module tb_fsm_core_arbiter;

`ifdef ARB_CTX_SAVE_EN
    localparam bit CTX_EN = 1'b1;
`else
    localparam bit CTX_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] core_x;
    logic       core_step;
    logic       core_load;
    logic [1:0] core_ctx;
    logic [1:0] core_state;
    logic [1:0] core_z;
    logic       busy;
    logic       grant_id;

    int checks = 0;
    int errors = 0;
    int step_cnt = 0;

    logic [3:0] exp_q [$];   // {id, z, last}
    logic [2:0] ld_q  [$];   // {grant_id, core_ctx}

    fsm_core_arbiter_if bus ();

    fsm_core_arbiter #(
        .CTX_RESET (2'b00),
        .MAX_LEN   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .core_x     (core_x),
        .core_step  (core_step),
        .core_load  (core_load),
        .core_ctx   (core_ctx),
        .core_state (core_state),
        .core_z     (core_z),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural core.
    initial core_state = 2'b00;
    always @(posedge clk) begin
        if (core_load)      core_state <= core_ctx;
        else if (core_step) core_state <= core_state + 2'd1;
    end
    assign core_z = core_state;

    always @(posedge clk) if (core_step) step_cnt <= step_cnt + 1;

    function automatic logic [14:0] all_outs();
        return {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_z, bus.rsp_id,
                bus.rsp_last, core_x, core_step, core_load, core_ctx, busy, grant_id};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_sym = 2'b00; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_sym = 2'b00; bus.req1_last = 1'b0;
        bus.rsp_ready = 1'b1;
        exp_q.delete();
        ld_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Presents an n-symbol packet on one requester, one symbol per handshake.
    task automatic drive_pkt(input bit id, input int n);
        bit hs;
        int wc;
        for (int i = 0; i < n; i++) begin
            if (id) begin
                bus.req1_valid = 1'b1; bus.req1_sym = 2'(i); bus.req1_last = (i == n - 1);
            end else begin
                bus.req0_valid = 1'b1; bus.req0_sym = 2'(i); bus.req0_last = (i == n - 1);
            end
            hs = 1'b0;
            wc = 0;
            while (!hs && wc < 200) begin
                @(negedge clk);
                hs = id ? bus.req1_ready : bus.req0_ready;
                @(posedge clk);
                #1;
                wc++;
            end
            if (!hs) begin
                checks++; errors++;
                $display("FAIL drive_timeout req%0d sym %0d: got no ready, want ready within 200 cycles", id, i);
                break;
            end
        end
        if (id) begin bus.req1_valid = 1'b0; bus.req1_last = 1'b0; end
        else    begin bus.req0_valid = 1'b0; bus.req0_last = 1'b0; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_sym = 2'b11; bus.req0_last = 1'b1;
        bus.req1_valid = 1'b0; bus.req1_sym = 2'b00; bus.req1_last = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs() !== 15'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0000", all_outs());
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, core_load} !== 2'b00) begin
            errors++; $display("FAIL reset_idle got busy,load=%b want 00", {busy, core_load});
        end
        @(negedge clk);
        checks++;
        if ({core_load, core_ctx, grant_id} !== 4'b1000) begin
            errors++; $display("FAIL reset_load got load,ctx,gid=%b want 1000", {core_load, core_ctx, grant_id});
        end
        @(negedge clk);
        checks++;
        if ({bus.req0_ready, bus.req1_ready, core_step, core_x} !== 5'b10111) begin
            errors++; $display("FAIL reset_run got rdy0,rdy1,step,x=%b want 10111",
                               {bus.req0_ready, bus.req1_ready, core_step, core_x});
        end
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_z, bus.rsp_last} !== 5'b10001) begin
            errors++; $display("FAIL reset_rsp got v,id,z,last=%b want 10001",
                               {bus.rsp_valid, bus.rsp_id, bus.rsp_z, bus.rsp_last});
        end
        bus.req0_valid = 1'b0;
        bus.req0_last  = 1'b0;
    endtask

    task automatic test_alternate();
        logic [1:0] c;
        logic [3:0] re;
        logic [2:0] le;
        int cyc;
        do_reset();
        c = CTX_EN ? 2'd2 : 2'd0;
        exp_q.push_back({1'b0, 2'd0, 1'b0}); exp_q.push_back({1'b0, 2'd1, 1'b1});
        exp_q.push_back({1'b1, 2'd0, 1'b0}); exp_q.push_back({1'b1, 2'd1, 1'b1});
        exp_q.push_back({1'b0, c, 1'b0});    exp_q.push_back({1'b0, c + 2'd1, 1'b1});
        ld_q.push_back({1'b0, 2'd0}); ld_q.push_back({1'b1, 2'd0}); ld_q.push_back({1'b0, c});
        fork
            begin drive_pkt(1'b0, 2); drive_pkt(1'b0, 2); end
            begin drive_pkt(1'b1, 2); end
            begin
                cyc = 0;
                while ((exp_q.size() != 0 || ld_q.size() != 0) && cyc < 300) begin
                    @(negedge clk); cyc++;
                    if (core_load) begin
                        checks++;
                        le = (ld_q.size() != 0) ? ld_q.pop_front() : 3'bxxx;
                        if ({grant_id, core_ctx} !== le) begin
                            errors++; $display("FAIL alt_load got gid,ctx=%b want %b", {grant_id, core_ctx}, le);
                        end
                    end
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        checks++;
                        re = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
                        if ({bus.rsp_id, bus.rsp_z, bus.rsp_last} !== re) begin
                            errors++; $display("FAIL alt_rsp got id,z,last=%b want %b",
                                               {bus.rsp_id, bus.rsp_z, bus.rsp_last}, re);
                        end
                    end
                end
                if (exp_q.size() != 0 || ld_q.size() != 0) begin
                    checks++; errors++;
                    $display("FAIL alt_timeout got %0d rsp %0d loads pending want 0", exp_q.size(), ld_q.size());
                end
            end
        join
    endtask

    task automatic test_max_len();
        logic [1:0] c3;
        logic [3:0] re;
        logic [2:0] le;
        int cyc;
        do_reset();
        c3 = CTX_EN ? 2'd3 : 2'd0;
        exp_q.push_back({1'b0, 2'd0, 1'b0}); exp_q.push_back({1'b0, 2'd1, 1'b0});
        exp_q.push_back({1'b0, 2'd2, 1'b1});
        exp_q.push_back({1'b0, c3, 1'b0});   exp_q.push_back({1'b0, c3 + 2'd1, 1'b1});
        ld_q.push_back({1'b0, 2'd0}); ld_q.push_back({1'b0, c3});
        fork
            begin drive_pkt(1'b0, 5); end
            begin
                cyc = 0;
                while ((exp_q.size() != 0 || ld_q.size() != 0) && cyc < 300) begin
                    @(negedge clk); cyc++;
                    if (core_load) begin
                        checks++;
                        le = (ld_q.size() != 0) ? ld_q.pop_front() : 3'bxxx;
                        if ({grant_id, core_ctx} !== le) begin
                            errors++; $display("FAIL maxlen_load got gid,ctx=%b want %b", {grant_id, core_ctx}, le);
                        end
                    end
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        checks++;
                        re = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
                        if ({bus.rsp_id, bus.rsp_z, bus.rsp_last} !== re) begin
                            errors++; $display("FAIL maxlen_rsp got id,z,last=%b want %b",
                                               {bus.rsp_id, bus.rsp_z, bus.rsp_last}, re);
                        end
                    end
                end
                if (exp_q.size() != 0 || ld_q.size() != 0) begin
                    checks++; errors++;
                    $display("FAIL maxlen_timeout got %0d rsp %0d loads pending want 0", exp_q.size(), ld_q.size());
                end
            end
        join
    endtask

    task automatic test_backpressure();
        logic [3:0] re;
        int base;
        int cyc;
        do_reset();
        bus.rsp_ready = 1'b0;
        base = step_cnt;
        exp_q.push_back({1'b0, 2'd0, 1'b0}); exp_q.push_back({1'b0, 2'd1, 1'b0});
        exp_q.push_back({1'b0, 2'd2, 1'b1});
        fork
            begin drive_pkt(1'b0, 3); end
            begin
                cyc = 0;
                while (!bus.rsp_valid && cyc < 50) begin
                    @(negedge clk); cyc++;
                end
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_z, bus.rsp_last, core_step} !== 6'b100000) begin
                        errors++; $display("FAIL stall_hold cycle %0d got v,id,z,last,step=%b want 100000",
                                           k, {bus.rsp_valid, bus.rsp_id, bus.rsp_z, bus.rsp_last, core_step});
                    end
                    if (k < 3) @(negedge clk);
                end
                checks++;
                if (step_cnt - base !== 1) begin
                    errors++; $display("FAIL stall_steps got %0d want 1", step_cnt - base);
                end
                @(posedge clk); #1 bus.rsp_ready = 1'b1;
                cyc = 0;
                while (exp_q.size() != 0 && cyc < 100) begin
                    @(negedge clk); cyc++;
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        checks++;
                        re = exp_q.pop_front();
                        if ({bus.rsp_id, bus.rsp_z, bus.rsp_last} !== re) begin
                            errors++; $display("FAIL stall_rsp got id,z,last=%b want %b",
                                               {bus.rsp_id, bus.rsp_z, bus.rsp_last}, re);
                        end
                    end
                end
                if (exp_q.size() != 0) begin
                    checks++; errors++;
                    $display("FAIL stall_timeout got %0d rsp pending want 0", exp_q.size());
                end
            end
        join
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] re;
        logic [2:0] le;
        int base;
        int cyc;
        do_reset();
        // A full packet first so req0 owns a non-reset context when saving.
        exp_q.push_back({1'b0, 2'd0, 1'b0}); exp_q.push_back({1'b0, 2'd1, 1'b1});
        fork
            begin drive_pkt(1'b0, 2); end
            begin
                cyc = 0;
                while (exp_q.size() != 0 && cyc < 100) begin
                    @(negedge clk); cyc++;
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        checks++;
                        re = exp_q.pop_front();
                        if ({bus.rsp_id, bus.rsp_z, bus.rsp_last} !== re) begin
                            errors++; $display("FAIL abort_pre_rsp got id,z,last=%b want %b",
                                               {bus.rsp_id, bus.rsp_z, bus.rsp_last}, re);
                        end
                    end
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
        base = step_cnt;
        bus.req0_valid = 1'b1; bus.req0_sym = 2'b01; bus.req0_last = 1'b0;
        cyc = 0;
        while (step_cnt - base < 2 && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        @(negedge clk);
        checks++;
        if ({busy, step_cnt - base == 2} !== 2'b11) begin
            errors++; $display("FAIL abort_midrun got busy=%b steps=%0d want busy=1 steps=2", busy, step_cnt - base);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 15'd0) begin
            errors++; $display("FAIL abort_outputs got %h want 0000", all_outs());
        end
        bus.req0_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.push_back({1'b0, 2'd0, 1'b1});
        ld_q.push_back({1'b0, 2'd0});
        fork
            begin drive_pkt(1'b0, 1); end
            begin
                cyc = 0;
                while ((exp_q.size() != 0 || ld_q.size() != 0) && cyc < 100) begin
                    @(negedge clk); cyc++;
                    if (core_load) begin
                        checks++;
                        le = (ld_q.size() != 0) ? ld_q.pop_front() : 3'bxxx;
                        if ({grant_id, core_ctx} !== le) begin
                            errors++; $display("FAIL abort_load got gid,ctx=%b want %b", {grant_id, core_ctx}, le);
                        end
                    end
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        checks++;
                        re = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
                        if ({bus.rsp_id, bus.rsp_z, bus.rsp_last} !== re) begin
                            errors++; $display("FAIL abort_rsp got id,z,last=%b want %b",
                                               {bus.rsp_id, bus.rsp_z, bus.rsp_last}, re);
                        end
                    end
                end
                if (exp_q.size() != 0 || ld_q.size() != 0) begin
                    checks++; errors++;
                    $display("FAIL abort_timeout got %0d rsp %0d loads pending want 0", exp_q.size(), ld_q.size());
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_max_len();
        test_backpressure();
        test_reset_mid_run();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
